// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encodings and owner codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the memory read latency; holds at zero.
module mem_lat_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a fixed-latency single-port memory.
// Define MEM_ARBITER_RR_EN for round-robin grants; default is data-over-fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [1:0]        state_dbg
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LATENCY - 1);

  // Handshake: a requester holds req (and its addr/data) high until it sees a
  // one-cycle ack; the arbiter samples requests only in IDLE, never in RESP.
  arb_state_e state, state_nxt;
  arb_owner_e owner;
  logic       we_q;
  logic       grant_d;
  logic       start;
  logic       lat_load, lat_dec, lat_zero;

`ifdef MEM_ARBITER_RR_EN
  arb_owner_e last_grant;

  assign grant_d = d_req & (~i_req | (last_grant == ARB_OWN_I));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= ARB_OWN_I;
    end else if (start) begin
      last_grant <= grant_d ? ARB_OWN_D : ARB_OWN_I;
    end
  end
`else
  assign grant_d = d_req;
`endif

  assign start = (state == ARB_IDLE) && (i_req || d_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      owner     <= ARB_OWN_I;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        owner     <= grant_d ? ARB_OWN_D : ARB_OWN_I;
        we_q      <= grant_d & d_we;
        mem_addr  <= grant_d ? d_addr : i_addr;
        mem_wdata <= grant_d ? d_wdata : '0;
      end
      // Read data is only meaningful once the latency counter has drained.
      if ((state == ARB_WAIT) && lat_zero && !we_q) begin
        if (owner == ARB_OWN_D) d_rdata <= mem_rdata;
        else                    i_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    lat_load  = 1'b0;
    lat_dec   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (start) state_nxt = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        lat_load  = 1'b1;
        state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        lat_dec = ~lat_zero;
        if (lat_zero) state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
        i_ack     = (owner == ARB_OWN_I);
        d_ack     = (owner == ARB_OWN_D);
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  mem_lat_counter #(.W(CW)) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  assign stall     = (i_req & ~i_ack) | (d_req & ~d_ack);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a uses MEM_LATENCY=1, instance b uses 4.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] addr);
    case (addr)
      32'h0000_0010: mem_val = 32'h0010_0093;
      32'h0000_0200: mem_val = 32'h1234_5678;
      default:       mem_val = addr ^ 32'hA5A5_0000;
    endcase
  endfunction

  // ---------------- instance a (MEM_LATENCY = 1) ----------------
  logic        a_rst, a_i_req, a_i_ack, a_d_req, a_d_we, a_d_ack;
  logic        a_mem_en, a_mem_we, a_stall;
  logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [1:0]  a_state;
  logic [31:0] a_pipe;

  always @(posedge clk) a_pipe <= (a_mem_en && !a_mem_we) ? mem_val(a_mem_addr) : 32'h0;
  assign a_mem_rdata = a_pipe;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .reset(a_rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ack(a_i_ack), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .stall(a_stall), .state_dbg(a_state)
  );

  // ---------------- instance b (MEM_LATENCY = 4) ----------------
  logic        b_rst, b_i_req, b_i_ack, b_d_req, b_d_we, b_d_ack;
  logic        b_mem_en, b_mem_we, b_stall;
  logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_state;
  logic [31:0] b_pipe[4];

  always @(posedge clk) begin
    b_pipe[0] <= (b_mem_en && !b_mem_we) ? mem_val(b_mem_addr) : 32'h0;
    for (int i = 1; i < 4; i++) b_pipe[i] <= b_pipe[i-1];
  end
  assign b_mem_rdata = b_pipe[3];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) dut_b (
    .clk(clk), .reset(b_rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall(b_stall), .state_dbg(b_state)
  );

  // Drivers: called just after a rising edge with instance a idle; cycle 0 is
  // the cycle the request is first presented.
  task automatic a_access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int ack_cyc, output int ack_cnt,
                          output int en_cnt, output logic en_we, output logic [31:0] en_addr,
                          output logic [31:0] en_wdata, output logic [7:0] stall_bits);
    bit acked;
    ack_cyc = -1; ack_cnt = 0; en_cnt = 0; en_we = 1'b0;
    en_addr = '0; en_wdata = '0; stall_bits = '0;
    if (is_d) begin
      a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
    end else begin
      a_i_req = 1'b1; a_i_addr = addr;
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acked = 1'b0;
      if (c < 8) stall_bits[c] = a_stall;
      if (a_mem_en) begin
        en_cnt++; en_we = a_mem_we; en_addr = a_mem_addr; en_wdata = a_mem_wdata;
      end
      if (a_i_ack || a_d_ack) begin
        ack_cnt++;
        if ((is_d ? a_d_ack : a_i_ack) && ack_cyc < 0) begin
          ack_cyc = c; acked = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (acked) begin
        a_i_req = 1'b0; a_d_req = 1'b0;
      end
    end
    a_i_req = 1'b0; a_d_req = 1'b0;
  endtask

  task automatic a_reset();
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  int          ack_cyc, ack_cnt, en_cnt, d_cyc, i_cyc, last_ack, en_cyc;
  logic        en_we;
  logic [31:0] en_addr, en_wdata;
  logic [7:0]  stall_bits;

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_i_req = 0; a_i_addr = 0; a_d_req = 0; a_d_we = 0; a_d_addr = 0; a_d_wdata = 0;
    b_i_req = 0; b_i_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst i_ack", a_i_ack, 0);
    check("rst d_ack", a_d_ack, 0);
    check("rst mem_en", a_mem_en, 0);
    check("rst mem_we", a_mem_we, 0);
    check("rst i_rdata", a_i_rdata, 0);
    check("rst d_rdata", a_d_rdata, 0);
    check("rst mem_addr", a_mem_addr, 0);
    check("rst mem_wdata", a_mem_wdata, 0);
    check("rst stall", a_stall, 0);
    check("rst state", a_state, 0);
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;

    // Fetch only.
    a_access(0, 0, 32'h10, 0, ack_cyc, ack_cnt, en_cnt, en_we, en_addr, en_wdata, stall_bits);
    check("fetch mem_en count", en_cnt, 1);
    check("fetch mem_we", en_we, 0);
    check("fetch mem_addr", en_addr, 32'h10);
    check("fetch ack cycle", ack_cyc, 3);
    check("fetch ack count", ack_cnt, 1);
    check("fetch i_rdata", a_i_rdata, 32'h0010_0093);
    check("fetch stall trace", stall_bits, 8'b0000_0111);

    // Load, then a store that must leave d_rdata alone.
    a_access(1, 0, 32'h40, 0, ack_cyc, ack_cnt, en_cnt, en_we, en_addr, en_wdata, stall_bits);
    check("load ack cycle", ack_cyc, 3);
    check("load d_rdata", a_d_rdata, 32'hA5A5_0040);
    a_access(1, 1, 32'h100, 32'hDEAD_BEEF, ack_cyc, ack_cnt, en_cnt, en_we, en_addr, en_wdata,
             stall_bits);
    check("store mem_en count", en_cnt, 1);
    check("store mem_we", en_we, 1);
    check("store mem_addr", en_addr, 32'h100);
    check("store mem_wdata", en_wdata, 32'hDEAD_BEEF);
    check("store ack cycle", ack_cyc, 3);
    check("store ack count", ack_cnt, 1);
    check("store d_rdata kept", a_d_rdata, 32'hA5A5_0040);
    check("store i_rdata kept", a_i_rdata, 32'h0010_0093);

    // Contention: both raised together, each drops after its own ack.
    a_reset();
    exp_q = {1'b1, 1'b0};
    d_cyc = -1; i_cyc = -1; ack_cnt = 0;
    a_i_req = 1; a_i_addr = 32'h10; a_d_req = 1; a_d_we = 0; a_d_addr = 32'h40;
    for (int c = 0; c < 14; c++) begin
      bit drop_i, drop_d;
      @(negedge clk);
      drop_i = a_i_ack; drop_d = a_d_ack;
      if (a_d_ack || a_i_ack) begin
        ack_cnt++;
        if (exp_q.size() > 0) check("contend order", a_d_ack, exp_q.pop_front());
        else check("contend extra ack", 1, 0);
        if (a_d_ack) d_cyc = c;
        if (a_i_ack) i_cyc = c;
      end
      @(posedge clk); #1;
      if (drop_i) a_i_req = 0;
      if (drop_d) a_d_req = 0;
    end
    a_i_req = 0; a_d_req = 0;
    check("contend d_ack cycle", d_cyc, 3);
    check("contend i_ack cycle", i_cyc, 7);
    check("contend ack count", ack_cnt, 2);
    check("contend i_rdata", a_i_rdata, 32'h0010_0093);

    // Both keep requesting for four accesses.
`ifdef MEM_ARBITER_RR_EN
    exp_q = {1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_q = {1'b1, 1'b1, 1'b1, 1'b1};
`endif
    ack_cnt = 0; last_ack = -1;
    a_i_req = 1; a_d_req = 1;
    for (int c = 0; c < 30 && ack_cnt < 4; c++) begin
      @(negedge clk);
      if (a_d_ack || a_i_ack) begin
        ack_cnt++;
        last_ack = c;
        if (exp_q.size() > 0) check("grant order", a_d_ack, exp_q.pop_front());
        else check("grant extra ack", 1, 0);
      end
      @(posedge clk); #1;
    end
    a_i_req = 0; a_d_req = 0;
    check("grant ack count", ack_cnt, 4);
    check("grant 4th ack cycle", last_ack, 15);
    repeat (3) @(posedge clk);
    #1;

    // Instance b: latency-4 load.
    en_cnt = 0; en_cyc = -1; ack_cyc = -1;
    b_d_req = 1; b_d_we = 0; b_d_addr = 32'h200;
    for (int c = 0; c < 12; c++) begin
      bit drop;
      @(negedge clk);
      drop = b_d_ack;
      if (b_mem_en) begin en_cnt++; en_cyc = c; end
      if (b_d_ack && ack_cyc < 0) ack_cyc = c;
      @(posedge clk); #1;
      if (drop) b_d_req = 0;
    end
    b_d_req = 0;
    check("lat4 mem_en count", en_cnt, 1);
    check("lat4 ack cycle", ack_cyc, 6);
    check("lat4 en-to-ack", ack_cyc - en_cyc, 5);
    check("lat4 d_rdata", b_d_rdata, 32'h1234_5678);

    // Reset during WAIT abandons the access.
    b_d_req = 1; b_d_addr = 32'h10;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("midwait state", b_state, 2);
    @(posedge clk); #1;
    b_rst = 1; b_d_req = 0;
    #1;
    check("midwait rst mem_en", b_mem_en, 0);
    check("midwait rst d_ack", b_d_ack, 0);
    check("midwait rst i_ack", b_i_ack, 0);
    check("midwait rst d_rdata", b_d_rdata, 0);
    check("midwait rst state", b_state, 0);
    @(negedge clk);
    b_rst = 0;
    ack_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b_d_ack || b_i_ack || b_mem_en) ack_cnt++;
    end
    check("midwait no activity", ack_cnt, 0);
    @(posedge clk); #1;
    ack_cyc = -1;
    b_d_req = 1;
    for (int c = 0; c < 12; c++) begin
      bit drop;
      @(negedge clk);
      drop = b_d_ack;
      if (b_d_ack && ack_cyc < 0) ack_cyc = c;
      @(posedge clk); #1;
      if (drop) b_d_req = 0;
    end
    b_d_req = 0;
    check("reissue ack cycle", ack_cyc, 6);
    check("reissue d_rdata", b_d_rdata, 32'h0010_0093);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
